ol_walker: RTL
==============

Name: ol_walker

Overview:
- Object List sequencer for the PVR ISP front end.
- Walks one tile's Object List in VRAM starting at a given address, and decodes each OL word (triangle strip, triangle array, quad array, link).
- For each primitive entry it computes the parameter address and drives the ISP parser through `render_poly`, then holds `opb_word` stable until `poly_drawn` returns.
- Follows link words until end-of-list, then reports done.

Parameters:
- MAX_ENTRIES, 4096: entries processed before a forced abort (runaway-list guard).
- CNT_W, 16: width of the entry/statistics counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin walking at ol_base (ignored while busy)
- ol_base  in  24  OL start byte address; bits [1:0] ignored
- param_base  in  24  parameter buffer base byte address
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of walk
- error  out  1  sticky until next accepted start; set on reserved type or MAX_ENTRIES
- ol_vram_rd  out  1  read request, held until ol_vram_valid
- ol_vram_addr  out  24  word-aligned read address
- ol_vram_din  in  32  read data, sampled when ol_vram_valid=1
- ol_vram_valid  in  1  read data valid / request acknowledge
- opb_word  out  32  current OL word presented to the ISP parser
- poly_addr  out  24  parameter byte address for the current primitive
- render_poly  out  1  one-cycle start pulse to the ISP parser
- poly_drawn  in  1  ISP parser completion pulse
- entry_count  out  CNT_W  primitive entries issued in this walk
- strip_count, array_count, quad_count  out  CNT_W  per-type counts (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state IDLE.
- A reset asserted mid-walk aborts immediately. No pending VRAM read is completed, and the ISP parser is not notified.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_POLY, FINISH.
- IDLE:
  - On start, latch `{ol_base[23:2],2'b00}` into `ol_vram_addr`.
  - Clear `entry_count`, the stats counters and `error`.
  - Set busy and go to FETCH.
  - `ol_vram_rd` is high the cycle after start.
- FETCH:
  - Hold `ol_vram_rd=1` with `ol_vram_addr` stable.
  - In the cycle `ol_vram_valid=1`, capture `ol_vram_din` into an internal word register and go to DECODE.
  - `ol_vram_rd` drops the next cycle.
  - A valid response with zero wait states is legal.
- DECODE, classified on word bits [31:29]:
  - 0xx, triangle strip: poly_addr = param_base + (word[20:0] << 2), truncated to 24 bits; go to ISSUE.
  - 100 triangle array or 101 quad array: same address calculation; go to ISSUE.
  - 111, link: if word[28]=1, end of list, go to FINISH. Otherwise `ol_vram_addr` = `{word[23:2],2'b00}`; go to FETCH.
  - 110, reserved: set error; go to FINISH.
- ISSUE:
  - Drive `opb_word` with the captured word.
  - Pulse `render_poly` for exactly one cycle; increment `entry_count`.
  - Go to WAIT_POLY.
  - `opb_word` and `poly_addr` remain stable from ISSUE until the cycle after `poly_drawn`.
- WAIT_POLY:
  - On `poly_drawn`, set `ol_vram_addr` += 4.
  - If entry_count == MAX_ENTRIES, set error and go to FINISH; otherwise go to FETCH.
  - `poly_drawn` seen in any other state is ignored.
- FINISH: pulse done for one cycle; clear busy in the same cycle; go to IDLE.
- Latency:
  - start → first `ol_vram_rd`: 1 cycle.
  - `ol_vram_valid` → `render_poly`: 2 cycles (DECODE, ISSUE).
  - `poly_drawn` → next `ol_vram_rd`: 1 cycle.
- Edge cases:
  - A start arriving in the same cycle as done is ignored.
  - Address wrap: `ol_vram_addr` +4 wraps modulo 2^24.
  - Counters saturate at all-ones.

Optional Feature:
- Macro: OL_WALKER_STATS_EN.
- Defined: `strip_count`, `array_count` and `quad_count` each increment in ISSUE, according to the type of the issued entry. They clear on an accepted start.
- Undefined: these three outputs are tied to 0 and no counter logic is generated. `entry_count` is always present.

Test Plan:
- Empty list:
  - Stimulus: ol_base=0x001000; VRAM[0x1000]=0xF0000000 (link with EOL).
  - Response: one read at 0x001000, no render_poly, done pulse, error=0, entry_count=0.
- Single strip:
  - Stimulus: param_base=0x100000; VRAM[0x1000]=0x00000010, then VRAM[0x1004]=0xF0000000.
  - Response: render_poly once with poly_addr=0x100040 and opb_word=0x00000010. The next read occurs at 0x001004 only after poly_drawn, followed by done with entry_count=1.
- Link follow:
  - Stimulus: VRAM[0x1000]=0x80000008 (triangle array); VRAM[0x1004]=0xE0002000 (link, no EOL); VRAM[0x2000]=0xA0000020 (quad array); VRAM[0x2004]=0xF0000000.
  - Response: reads at 0x1000, 0x1004, 0x2000, 0x2004. With OL_WALKER_STATS_EN defined, array_count=1 and quad_count=1.
- Reserved type:
  - Stimulus: VRAM[0x1000]=0xC0000000.
  - Response: no render_poly; error=1 and done pulse.
- Handshake stall:
  - Stimulus: hold ol_vram_valid low for 5 cycles; hold poly_drawn off for 20 cycles.
  - Response: ol_vram_rd and ol_vram_addr stay stable throughout the stall; opb_word stays stable throughout; render_poly is asserted exactly once.
- Reset mid-walk:
  - Stimulus: assert reset during WAIT_POLY.
  - Response: all outputs return to 0 asynchronously; a later start walks cleanly from ol_base.

Source files
------------

// File: rtl/ol_walker_if.sv
// VRAM read port and ISP parser handshake shared by the OL walker and its neighbours.
interface ol_walker_if;
    logic        ol_vram_rd;
    logic [23:0] ol_vram_addr;
    logic [31:0] ol_vram_din;
    logic        ol_vram_valid;
    logic [31:0] opb_word;
    logic [23:0] poly_addr;
    logic        render_poly;
    logic        poly_drawn;

    modport master (
        output ol_vram_rd, ol_vram_addr, opb_word, poly_addr, render_poly,
        input  ol_vram_din, ol_vram_valid, poly_drawn
    );

    modport slave (
        input  ol_vram_rd, ol_vram_addr, opb_word, poly_addr, render_poly,
        output ol_vram_din, ol_vram_valid, poly_drawn
    );
endinterface

// File: rtl/ol_walker.sv
// Object List walker: fetches OL words from VRAM, issues primitives to the ISP parser, follows links.
// Define OL_WALKER_STATS_EN to build the per-type strip/array/quad counters.
module ol_walker #(
    parameter int unsigned MAX_ENTRIES = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      ol_base,
    input  logic [23:0]      param_base,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] entry_count,
    output logic [CNT_W-1:0] strip_count,
    output logic [CNT_W-1:0] array_count,
    output logic [CNT_W-1:0] quad_count,
    ol_walker_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_POLY,
        S_FINISH
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [23:0]      r_addr;
    logic [23:0]      r_poly_addr;
    logic [31:0]      r_word;
    logic [31:0]      r_opb;
    logic             r_error;
    logic [CNT_W-1:0] r_entry;

    logic             w_rd;
    logic             w_render;
    logic             w_busy;
    logic             w_done;
    logic             w_is_prim;
    logic             w_is_link;
    logic             w_is_rsvd;
    logic             w_max_hit;
    logic [23:0]      w_poly_calc;
    logic             w_unused;

    assign w_is_prim   = !r_word[31] || (r_word[31:30] == 2'b10);
    assign w_is_link   = (r_word[31:29] == 3'b111);
    assign w_is_rsvd   = (r_word[31:29] == 3'b110);
    assign w_max_hit   = (r_entry == CNT_W'(MAX_ENTRIES));
    assign w_poly_calc = param_base + {1'b0, r_word[20:0], 2'b00};
    assign w_unused    = ^ol_base[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_rd     = 1'b0;
        w_render = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_rd   = 1'b1;
                w_busy = 1'b1;
                if (bus.ol_vram_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_busy = 1'b1;
                if (w_is_prim)      w_next = S_ISSUE;
                else if (w_is_link) w_next = r_word[28] ? S_FINISH : S_FETCH;
                else                w_next = S_FINISH;
            end
            S_ISSUE: begin
                w_busy   = 1'b1;
                w_render = 1'b1;
                w_next   = S_WAIT_POLY;
            end
            S_WAIT_POLY: begin
                w_busy = 1'b1;
                if (bus.poly_drawn) w_next = w_max_hit ? S_FINISH : S_FETCH;
            end
            S_FINISH: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // opb_word/poly_addr only reload on a primitive decode, so they hold through the poly_drawn wait
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_poly_addr <= '0;
            r_word      <= '0;
            r_opb       <= '0;
            r_error     <= 1'b0;
            r_entry     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= {ol_base[23:2], 2'b00};
                        r_entry <= '0;
                        r_error <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (bus.ol_vram_valid) r_word <= bus.ol_vram_din;
                end
                S_DECODE: begin
                    if (w_is_prim) begin
                        r_poly_addr <= w_poly_calc;
                        r_opb       <= r_word;
                    end else if (w_is_link && !r_word[28]) begin
                        r_addr <= {r_word[23:2], 2'b00};
                    end else if (w_is_rsvd) begin
                        r_error <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_entry != '1) r_entry <= r_entry + 1'b1;
                end
                S_WAIT_POLY: begin
                    if (bus.poly_drawn) begin
                        r_addr <= r_addr + 24'd4;
                        if (w_max_hit) r_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OL_WALKER_STATS_EN
    logic [CNT_W-1:0] r_strip;
    logic [CNT_W-1:0] r_array;
    logic [CNT_W-1:0] r_quad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_strip <= '0;
            r_array <= '0;
            r_quad  <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_strip <= '0;
            r_array <= '0;
            r_quad  <= '0;
        end else if (r_state == S_ISSUE) begin
            if (!r_opb[31]) begin
                if (r_strip != '1) r_strip <= r_strip + 1'b1;
            end else if (!r_opb[29]) begin
                if (r_array != '1) r_array <= r_array + 1'b1;
            end else begin
                if (r_quad != '1) r_quad <= r_quad + 1'b1;
            end
        end
    end

    assign strip_count = r_strip;
    assign array_count = r_array;
    assign quad_count  = r_quad;
`else
    assign strip_count = '0;
    assign array_count = '0;
    assign quad_count  = '0;
`endif

    assign busy             = w_busy;
    assign done             = w_done;
    assign error            = r_error;
    assign entry_count      = r_entry;
    assign bus.ol_vram_rd   = w_rd;
    assign bus.ol_vram_addr = r_addr;
    assign bus.opb_word     = r_opb;
    assign bus.poly_addr    = r_poly_addr;
    assign bus.render_poly  = w_render;

endmodule
